// File: rtl/ltc2324_frame_ctrl.sv
// Frame controller for an LTC2324 capture path: gates the ADC driver, packs the
// four channels into 64-bit beats and buffers them for an AXI4-Stream master.
module ltc2324_frame_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [LEN_W-1:0] frame_len,
  output logic             sample_en,
  input  logic             adc_valid,
  input  logic [15:0]      adc_ch1,
  input  logic [15:0]      adc_ch2,
  input  logic [15:0]      adc_ch3,
  input  logic [15:0]      adc_ch4,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             cont_reg;
  logic             stop_pend_reg;
  logic             sample_en_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             overflow_reg;

  logic [64:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             tvalid_reg;
  logic             tvalid_next;
  logic             tlast_reg;
  logic [63:0]      tdata_reg;

  logic             in_run;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             last_bit;

  assign in_run   = (state_reg == ST_RUN);
  assign full     = (count_reg == CNT_FULL);
  assign pop      = tvalid_reg & m_axis_tready;
  // A pop frees a slot in the same cycle, so a full buffer can still accept.
  assign push     = in_run & adc_valid & (~full | pop);
  assign drop     = in_run & adc_valid & full & ~pop;
  assign last_bit = (cnt_reg == len_reg - LEN_ONE);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
  // Only entries stored before this edge may become the head, so a freshly
  // written word appears one cycle after its write.
  assign tvalid_next = pop ? (count_reg > CNT_ONE) : (count_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      len_reg       <= LEN_ONE;
      cnt_reg       <= '0;
      cont_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
      sample_en_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_RUN;
            len_reg       <= (frame_len == '0) ? LEN_ONE : frame_len;
            cont_reg      <= continuous;
            cnt_reg       <= '0;
            overflow_reg  <= 1'b0;
            stop_pend_reg <= 1'b0;
            sample_en_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            stop_pend_reg <= 1'b1;
          end
          if (drop) begin
            overflow_reg <= 1'b1;
          end
          if (push) begin
            if (last_bit) begin
              cnt_reg <= '0;
              if (!cont_reg || stop_pend_reg || stop) begin
                state_reg     <= ST_DRAIN;
                sample_en_reg <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + LEN_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (count_next == '0) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            stop_pend_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          sample_en_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {last_bit, adc_ch4, adc_ch3, adc_ch2, adc_ch1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tdata_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      tvalid_reg <= tvalid_next;
      if (tvalid_next) begin
        {tlast_reg, tdata_reg} <= mem[rd_ptr_next];
      end
    end
  end

  assign sample_en     = sample_en_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign overflow      = overflow_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tdata  = tdata_reg;

endmodule

// File: tb/tb_ltc2324_frame_ctrl.sv
// Directed bench for ltc2324_frame_ctrl: framing, stop handling, backpressure,
// overflow, corner frame lengths and asynchronous reset.
module tb_ltc2324_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic        sample_en;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_ch1 = 16'd0;
    logic [15:0] adc_ch2 = 16'd0;
    logic [15:0] adc_ch3 = 16'd0;
    logic [15:0] adc_ch4 = 16'd0;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [64:0] beats[$];

    ltc2324_frame_ctrl #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .continuous(continuous), .frame_len(frame_len), .sample_en(sample_en),
        .adc_valid(adc_valid), .adc_ch1(adc_ch1), .adc_ch2(adc_ch2),
        .adc_ch3(adc_ch3), .adc_ch4(adc_ch4), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            beats.push_back({m_axis_tlast, m_axis_tdata});
            $display("[TB] beat %0d: tlast=%0d tdata=%h", beats.size(), m_axis_tlast, m_axis_tdata);
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int k);
        logic [15:0] s;
        s = k[15:0];
        mk = {16'h4000 + s, 16'h3000 + s, 16'h2000 + s, 16'h1000 + s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one sample for exactly one active edge.
    task automatic send(input int k);
        logic [15:0] s;
        s = k[15:0];
        adc_ch1 = 16'h1000 + s;
        adc_ch2 = 16'h2000 + s;
        adc_ch3 = 16'h3000 + s;
        adc_ch4 = 16'h4000 + s;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic begin_run(input logic [15:0] len, input logic cont, input logic with_stop);
        frame_len = len;
        continuous = cont;
        start = 1'b1;
        stop = with_stop;
        tick();
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc && busy; i++) tick();
        check("idle_timeout", busy, 1'b0);
        ticks(2);
    endtask

    task automatic clear_log();
        beats.delete();
        done_cnt = 0;
    endtask

    initial begin
        // Reset asserted between edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst_sample_en", sample_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        #14 rst_n = 1'b1;
        tick();

        // Single frame of three with latency check.
        $display("[TB] single frame, len=3");
        clear_log();
        m_axis_tready = 1'b1;
        begin_run(16'd3, 1'b0, 1'b0);
        check("t1_busy", busy, 1'b1);
        check("t1_sample_en", sample_en, 1'b1);
        send(1);
        check("t1_lat_tvalid_n", m_axis_tvalid, 1'b0);
        tick();
        check("t1_lat_tvalid_n1", m_axis_tvalid, 1'b1);
        check("t1_lat_tdata", m_axis_tdata, mk(1));
        check("t1_lat_tlast", m_axis_tlast, 1'b0);
        send(2);
        check("t1_sample_en_mid", sample_en, 1'b1);
        send(3);
        check("t1_sample_en_drop", sample_en, 1'b0);
        check("t1_busy_drain", busy, 1'b1);
        wait_idle(20);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_beats", beats.size(), 3);
        check("t1_beat1", beats[0], {1'b0, mk(1)});
        check("t1_beat2", beats[1], {1'b0, mk(2)});
        check("t1_beat3", beats[2], {1'b1, mk(3)});

        // Continuous frames of two, stop after sample 3.
        $display("[TB] continuous len=2 with stop");
        clear_log();
        begin_run(16'd2, 1'b1, 1'b0);
        send(11); tick();
        send(12);
        check("t2_stay_run", sample_en, 1'b1);
        tick();
        send(13);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t2_stop_wait", sample_en, 1'b1);
        send(14);
        check("t2_sample_en_drop", sample_en, 1'b0);
        wait_idle(20);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_beats", beats.size(), 4);
        check("t2_beat1", beats[0], {1'b0, mk(11)});
        check("t2_beat2", beats[1], {1'b1, mk(12)});
        check("t2_beat3", beats[2], {1'b0, mk(13)});
        check("t2_beat4", beats[3], {1'b1, mk(14)});

        // Backpressure with overflow, len=6.
        $display("[TB] backpressure and overflow");
        clear_log();
        m_axis_tready = 1'b0;
        begin_run(16'd6, 1'b0, 1'b0);
        for (int k = 21; k <= 26; k++) send(k);
        check("t3_overflow", overflow, 1'b1);
        check("t3_tvalid", m_axis_tvalid, 1'b1);
        check("t3_head", m_axis_tdata, mk(21));
        ticks(3);
        check("t3_hold_tdata", m_axis_tdata, mk(21));
        check("t3_hold_tvalid", m_axis_tvalid, 1'b1);
        check("t3_hold_tlast", m_axis_tlast, 1'b0);
        check("t3_still_run", sample_en, 1'b1);
        m_axis_tready = 1'b1;
        ticks(8);
        check("t3_beats4", beats.size(), 4);
        check("t3_beat1", beats[0], {1'b0, mk(21)});
        check("t3_beat2", beats[1], {1'b0, mk(22)});
        check("t3_beat3", beats[2], {1'b0, mk(23)});
        check("t3_beat4", beats[3], {1'b0, mk(24)});
        // Counter sits at 4, so two more samples close the frame.
        send(27); tick();
        send(28);
        check("t3_frame_end", sample_en, 1'b0);
        wait_idle(20);
        check("t3_beats6", beats.size(), 6);
        check("t3_beat5", beats[4], {1'b0, mk(27)});
        check("t3_beat6", beats[5], {1'b1, mk(28)});
        check("t3_ovf_sticky", overflow, 1'b1);

        // Full buffer with simultaneous pop and write.
        $display("[TB] full fifo with simultaneous pop");
        clear_log();
        m_axis_tready = 1'b0;
        begin_run(16'd5, 1'b0, 1'b0);
        check("t4_ovf_cleared", overflow, 1'b0);
        for (int k = 31; k <= 34; k++) send(k);
        m_axis_tready = 1'b1;
        send(35);
        check("t4_no_overflow", overflow, 1'b0);
        check("t4_drain", sample_en, 1'b0);
        wait_idle(20);
        check("t4_beats", beats.size(), 5);
        check("t4_beat1", beats[0], {1'b0, mk(31)});
        check("t4_beat4", beats[3], {1'b0, mk(34)});
        check("t4_beat5", beats[4], {1'b1, mk(35)});
        check("t4_overflow_end", overflow, 1'b0);

        // frame_len=0 continuous, start and stop together, then IDLE samples.
        $display("[TB] frame_len=0 and idle samples");
        clear_log();
        begin_run(16'd0, 1'b1, 1'b1);
        send(41);
        check("t5_start_wins", sample_en, 1'b1);
        tick();
        send(42); tick();
        send(43); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        send(44);
        check("t5_stop_drain", sample_en, 1'b0);
        wait_idle(20);
        check("t5_beats", beats.size(), 4);
        check("t5_beat1", beats[0], {1'b1, mk(41)});
        check("t5_beat2", beats[1], {1'b1, mk(42)});
        check("t5_beat3", beats[2], {1'b1, mk(43)});
        check("t5_beat4", beats[3], {1'b1, mk(44)});
        send(45);
        send(46);
        ticks(5);
        check("t5_idle_beats", beats.size(), 4);
        check("t5_idle_tvalid", m_axis_tvalid, 1'b0);
        check("t5_idle_busy", busy, 1'b0);
        check("t5_idle_ovf", overflow, 1'b0);

        // Asynchronous reset mid-frame.
        $display("[TB] async reset mid-frame");
        clear_log();
        m_axis_tready = 1'b0;
        begin_run(16'd8, 1'b0, 1'b0);
        for (int k = 51; k <= 55; k++) send(k);
        check("t6_pre_overflow", overflow, 1'b1);
        check("t6_pre_tvalid", m_axis_tvalid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_sample_en", sample_en, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_overflow", overflow, 1'b0);
        check("t6_rst_tvalid", m_axis_tvalid, 1'b0);
        check("t6_rst_tlast", m_axis_tlast, 1'b0);
        check("t6_rst_tdata", m_axis_tdata, 64'd0);
        #2 rst_n = 1'b1;
        m_axis_tready = 1'b1;
        ticks(4);
        check("t6_no_leftover", beats.size(), 0);
        begin_run(16'd2, 1'b0, 1'b0);
        send(61); tick();
        send(62);
        wait_idle(20);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_beats", beats.size(), 2);
        check("t6_beat1", beats[0], {1'b0, mk(61)});
        check("t6_beat2", beats[1], {1'b1, mk(62)});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ltc2324_frame_ctrl.md
LTC2324_FRAME_CTRL -- requirements
Module: ltc2324_frame_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning captured-sample buffer entries (power of 2, >=2).
REQ-002 Parameter LEN_W, default 16, meaning width of frame_len and the sample counter.
REQ-003 Port clk, input, 1, the single clock for all logic, same domain as the ADC driver.
REQ-004 Port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-005 Port start, input, 1, one-cycle pulse that begins acquisition; ignored unless in IDLE.
REQ-006 Port stop, input, 1, one-cycle pulse requesting a graceful stop at the next frame boundary.
REQ-007 Port continuous, input, 1, 1 = repeat frames until stop, 0 = single frame; latched on accepted start.
REQ-008 Port frame_len, input, LEN_W, samples per frame; latched on accepted start; value 0 treated as 1.
REQ-009 Port sample_en, output, 1, enable to the ADC driver.
REQ-010 Port adc_valid, input, 1, one-cycle strobe from the ADC driver marking ch1..ch4 valid.
REQ-011 Port adc_ch1..adc_ch4, input, 16 each, conversion results.
REQ-012 Port m_axis_tdata, output, 64, {ch4,ch3,ch2,ch1}.
REQ-013 Port m_axis_tvalid / m_axis_tready / m_axis_tlast, output / input / output, 1 each, AXI4-Stream master.
REQ-014 Port busy, output, 1, high in every state except IDLE.
REQ-015 Port done, output, 1, one-cycle pulse on the DRAIN to IDLE transition.
REQ-016 Port overflow, output, 1, sticky flag indicating at least one sample was dropped.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 IDLE to RUN on start; the same edge latches frame_len/continuous, clears the sample counter, and clears overflow.
REQ-019 sample_en is registered and equals 1 only while in RUN.
REQ-020 In RUN, adc_valid with the FIFO not full writes {ch4,ch3,ch2,ch1} plus a last bit; accepted samples increment the counter.
REQ-021 The last bit is 1 when the accepted sample is number frame_len of the frame; the counter returns to 0 on that sample.
REQ-022 At a frame end with continuous=0 or with a stop pending, the FSM goes RUN to DRAIN on the same edge as the write; otherwise it stays in RUN.
REQ-023 Stop is recorded as pending in RUN and honoured at the next frame end.
REQ-024 Stop in IDLE or DRAIN is ignored.
REQ-025 Start and stop arriving in the same IDLE cycle: start wins and the stop is discarded.
REQ-026 adc_valid in IDLE or DRAIN is discarded: no write, no count, no overflow.
REQ-027 adc_valid in RUN with the FIFO full and no pop in that cycle drops the sample, sets overflow, and does not count the sample.
REQ-028 Full FIFO with a pop (tvalid&tready) in the same cycle as adc_valid accepts the write.
REQ-029 DRAIN holds sample_en=0 until the FIFO is empty, then goes to IDLE with done=1 for that one cycle.
REQ-030 Write latency: adc_valid at edge N makes the data visible on m_axis_tdata with tvalid=1 after edge N+1.
REQ-031 FIFO order is strict FIFO; simultaneous push and pop keep occupancy unchanged.
REQ-032 Pointers wrap modulo FIFO_DEPTH.
REQ-033 While tvalid=1 and tready=0, tdata, tlast and tvalid are held stable.
REQ-034 tlast is the stored last bit of the head entry.

Reset
REQ-035 rst_n low forces IDLE, sample_en=0, busy=0, done=0, overflow=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, counter=0, FIFO empty, and no pending stop, immediately and regardless of clk.
REQ-036 Reset mid-frame discards all buffered samples, with no partial tlast emitted afterwards.

Verification
REQ-037 Single frame: frame_len=3, continuous=0, start, three adc_valid, tready=1 -> three beats, tlast on beat 3 only, sample_en drops on the third write edge, done pulses once, busy low after.
REQ-038 Continuous + stop: frame_len=2, continuous=1, stop pulsed after sample 3 -> four beats, tlast on beats 2 and 4, sample_en low after sample 4, done once.
REQ-039 Backpressure/overflow: FIFO_DEPTH=4, tready=0, six adc_valid in RUN -> four entries held, overflow=1, counter=4; release tready -> the four beats emerge in order with unchanged data.
REQ-040 Full FIFO with simultaneous pop: FIFO full, tready=1 and adc_valid in the same cycle -> write accepted, overflow remains 0.
REQ-041 Corner inputs: frame_len=0 -> every beat has tlast=1; adc_valid while IDLE -> no beat emitted.
REQ-042 Async reset: rst_n pulsed low between clock edges mid-frame -> all outputs reach reset values before the next edge, and a new start behaves as a first run.
